// File: rtl/test_cam_pkg.sv
// Shared constants and types for the camera-to-VGA loopback: capture geometry,
// frame-buffer addressing and 640x480@60 VGA timing.
package test_cam_pkg;
    localparam int unsigned IMG_W  = 160;
    localparam int unsigned IMG_H  = 120;
    localparam int unsigned FB_AW  = 15;

    localparam int unsigned H_VIS  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;
    localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;
endpackage

// File: rtl/test_cam_cam_read.sv
// Camera capture: 2-FF sync of all camera inputs, pclk rise detect, two-byte
// RGB444 assembly and write-address generation; writes arm at the first vsync after reset.
module cam_read
    import test_cam_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_W * IMG_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pclk_i,
    input  logic             vsync_i,
    input  logic             href_i,
    input  logic [7:0]       d_i,
    output logic             wr_vld_o,
    output logic [FB_AW-1:0] wr_addr_o,
    output rgb444_t          wr_dat_o
);
    localparam logic [FB_AW-1:0] DEPTH_A = FB_AW'(DEPTH);

    logic [10:0]      sync1_q, sync2_q;
    logic             pclk_prev_q;
    logic             phase_q, phase_d;
    logic             armed_q, armed_d;
    logic [3:0]       red_q, red_d;
    logic [FB_AW-1:0] addr_q, addr_d;
    logic             wr_vld_q, wr_vld_d;
    logic [FB_AW-1:0] wr_addr_q, wr_addr_d;
    rgb444_t          wr_dat_q, wr_dat_d;

    logic       s_pclk, s_vsync, s_href, rise;
    logic [7:0] s_d;

    assign {s_pclk, s_vsync, s_href, s_d} = sync2_q;
    assign rise = s_pclk & ~pclk_prev_q;

    always_comb begin
        phase_d   = phase_q;
        armed_d   = armed_q;
        red_d     = red_q;
        addr_d    = addr_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        if (rise) begin
            if (s_vsync) begin
                addr_d  = '0;
                phase_d = 1'b0;
                armed_d = 1'b1;
            end else if (!s_href) begin
                phase_d = 1'b0;
            end else if (!phase_q) begin
                red_d   = s_d[3:0];
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                // Past the end of the buffer the pixel is dropped and the address parks.
                if (armed_q && (addr_q < DEPTH_A)) begin
                    wr_vld_d  = 1'b1;
                    wr_addr_d = addr_q;
                    wr_dat_d  = {red_q, s_d[7:4], s_d[3:0]};
                    addr_d    = addr_q + FB_AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            pclk_prev_q <= 1'b0;
            phase_q     <= 1'b0;
            armed_q     <= 1'b0;
            red_q       <= '0;
            addr_q      <= '0;
            wr_vld_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_dat_q    <= '0;
        end else begin
            sync1_q     <= {pclk_i, vsync_i, href_i, d_i};
            sync2_q     <= sync1_q;
            pclk_prev_q <= s_pclk;
            phase_q     <= phase_d;
            armed_q     <= armed_d;
            red_q       <= red_d;
            addr_q      <= addr_d;
            wr_vld_q    <= wr_vld_d;
            wr_addr_q   <= wr_addr_d;
            wr_dat_q    <= wr_dat_d;
        end
    end

    assign wr_vld_o  = wr_vld_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_dat_o  = wr_dat_q;
endmodule

// File: rtl/test_cam_top.sv
// Camera capture -> frame buffer -> 640x480 VGA. Outputs update once per 4 clk;
// define TEST_CAM_UPSCALE_EN to replicate each stored pixel 4x4 to fill the screen.
module test_cam_top
    import test_cam_pkg::*;
#(
    parameter int unsigned IMG_W_P  = IMG_W,
    parameter int unsigned IMG_H_P  = IMG_H,
    parameter int unsigned H_VIS_P  = H_VIS,
    parameter int unsigned H_FP_P   = H_FP,
    parameter int unsigned H_SYNC_P = H_SYNC,
    parameter int unsigned H_BP_P   = H_BP,
    parameter int unsigned V_VIS_P  = V_VIS,
    parameter int unsigned V_FP_P   = V_FP,
    parameter int unsigned V_SYNC_P = V_SYNC,
    parameter int unsigned V_BP_P   = V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CAM_pclk,
    input  logic       CAM_vsync,
    input  logic       CAM_href,
    input  logic       CAM_D0,
    input  logic       CAM_D1,
    input  logic       CAM_D2,
    input  logic       CAM_D3,
    input  logic       CAM_D4,
    input  logic       CAM_D5,
    input  logic       CAM_D6,
    input  logic       CAM_D7,
    output logic       CAM_xclk,
    output logic       CAM_pwdn,
    output logic       CAM_reset,
    output logic       VGA_Hsync_n,
    output logic       VGA_Vsync_n,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B
);
    localparam int unsigned DEPTH = IMG_W_P * IMG_H_P;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [9:0] H_LAST  = 10'(H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS_P + H_FP_P);
    localparam logic [9:0] HS_END  = 10'(H_VIS_P + H_FP_P + H_SYNC_P - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS_P + V_FP_P);
    localparam logic [9:0] VS_END  = 10'(V_VIS_P + V_FP_P + V_SYNC_P - 1);
    localparam logic [9:0] IMG_W_C = 10'(IMG_W_P);
    localparam logic [9:0] IMG_H_C = 10'(IMG_H_P);

    logic             wr_vld;
    logic [FB_AW-1:0] wr_addr;
    rgb444_t          wr_dat;

    cam_read #(.DEPTH(DEPTH)) u_cam_read (
        .clk       (clk),
        .rst       (rst),
        .pclk_i    (CAM_pclk),
        .vsync_i   (CAM_vsync),
        .href_i    (CAM_href),
        .d_i       ({CAM_D7, CAM_D6, CAM_D5, CAM_D4, CAM_D3, CAM_D2, CAM_D1, CAM_D0}),
        .wr_vld_o  (wr_vld),
        .wr_addr_o (wr_addr),
        .wr_dat_o  (wr_dat)
    );

    logic [1:0] div_q;
    logic       pix_en;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       hs_n_q, vs_n_q;
    rgb444_t    rgb_q, rd_dat_q;

    assign pix_en = (div_q == 2'd3);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    logic [9:0]       px, py;
    logic             in_vis, in_img;
    logic [FB_AW-1:0] rd_addr;

    always_comb begin
`ifdef TEST_CAM_UPSCALE_EN
        px     = h_q >> 2;
        py     = v_q >> 2;
        in_vis = (h_q < 10'(H_VIS_P)) && (v_q < 10'(V_VIS_P));
`else
        px     = h_q;
        py     = v_q;
        in_vis = 1'b1;
`endif
        in_img  = in_vis && (px < IMG_W_C) && (py < IMG_H_C);
        rd_addr = in_img ? (FB_AW'(py) * FB_AW'(IMG_W_P) + FB_AW'(px)) : '0;
    end

    // Read-before-write on a same-address collision returns the old pixel.
    rgb444_t mem [DEPTH];
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_dat;
        end
        rd_dat_q <= mem[rd_addr[IDX_W-1:0]];
    end

    // The counter is stable for 4 clk, so rd_dat_q already matches it on pix_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            hs_n_q <= 1'b1;
            vs_n_q <= 1'b1;
            rgb_q  <= '0;
        end else begin
            div_q <= div_q + 2'd1;
            h_q   <= h_d;
            v_q   <= v_d;
            if (pix_en) begin
                hs_n_q <= !((h_q >= HS_BEG) && (h_q <= HS_END));
                vs_n_q <= !((v_q >= VS_BEG) && (v_q <= VS_END));
                rgb_q  <= in_img ? rd_dat_q : '0;
            end
        end
    end

    assign CAM_xclk    = div_q[1];
    assign CAM_pwdn    = 1'b0;
    assign CAM_reset   = 1'b1;
    assign VGA_Hsync_n = hs_n_q;
    assign VGA_Vsync_n = vs_n_q;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
endmodule

// File: tb/tb_test_cam_top.sv
// Bench for test_cam_top with full horizontal timing and a shortened frame
// (3 image lines, 8 screen lines) so two whole VGA frames fit in the run.
module tb_test_cam_top;
    localparam int IMG_W = 160;
    localparam int IMG_H = 3;
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_VIS = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int END_EDGES = 4 * (2 * FRAME) + 40;

    logic       clk = 1'b0, rst = 1'b1;
    logic       pclk = 1'b0, vsync = 1'b0, href = 1'b0;
    logic [7:0] d = 8'h00;
    logic       xclk, pwdn, cam_rst, hs_n, vs_n;
    logic [3:0] vr, vg, vb;

    int n_chk = 0, n_fail = 0;
    int edges = 0;
    logic run_chk = 1'b0, chk_rgb = 1'b0;

    logic [11:0] exp_mem [DEPTH];
    int          m_addr = 0, m_phase = 0;
    logic [3:0]  m_red = 4'h0;
    logic [7:0]  pat [8] = '{8'h00, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'hF0};
    logic [11:0] lit_line0 [4] = '{12'h00F, 12'h00F, 12'h0F0, 12'h0F0};

    always #5 clk = ~clk;

    test_cam_top #(
        .IMG_W_P(IMG_W), .IMG_H_P(IMG_H),
        .H_VIS_P(H_VIS), .H_FP_P(H_FP), .H_SYNC_P(H_SYNC), .H_BP_P(H_BP),
        .V_VIS_P(V_VIS), .V_FP_P(V_FP), .V_SYNC_P(V_SYNC), .V_BP_P(V_BP)
    ) dut (
        .clk(clk), .rst(rst),
        .CAM_pclk(pclk), .CAM_vsync(vsync), .CAM_href(href),
        .CAM_D0(d[0]), .CAM_D1(d[1]), .CAM_D2(d[2]), .CAM_D3(d[3]),
        .CAM_D4(d[4]), .CAM_D5(d[5]), .CAM_D6(d[6]), .CAM_D7(d[7]),
        .CAM_xclk(xclk), .CAM_pwdn(pwdn), .CAM_reset(cam_rst),
        .VGA_Hsync_n(hs_n), .VGA_Vsync_n(vs_n),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at edge %0d", name, act, req, edges);
        end
    endtask

    // Capture rules applied byte by byte to build the expected frame buffer.
    task automatic model_byte(input logic vs, input logic hr, input logic [7:0] b);
        if (vs) begin
            m_addr = 0;
            m_phase = 0;
        end else if (!hr) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_red = b[3:0];
            m_phase = 1;
        end else begin
            if (m_addr < DEPTH) begin
                exp_mem[m_addr] = {m_red, b};
                m_addr++;
            end
            m_phase = 0;
        end
    endtask

    task automatic put_byte(input logic vs, input logic hr, input logic [7:0] b);
        @(posedge clk); #1;
        pclk = 1'b0; vsync = vs; href = hr; d = b;
        @(posedge clk); #1;
        pclk = 1'b1;
        model_byte(vs, hr, b);
    endtask

    task automatic idle(input logic vs, input int n);
        for (int i = 0; i < n; i++) put_byte(vs, 1'b0, 8'h00);
    endtask

    task automatic pattern_line();
        for (int i = 0; i < 2 * IMG_W; i++) put_byte(1'b0, 1'b1, pat[i % 8]);
    endtask

    // Clock edges since reset release; the model's notion of time.
    initial forever begin
        @(posedge clk);
        edges = rst ? 0 : edges + 1;
    end

    initial begin : compare
        int k, p, x, y, a, hs_cnt, vs_cnt;
        logic in_img, seen_hs, exp_hs, exp_vs;
        logic [11:0] rgb;
        hs_cnt = 0; vs_cnt = 0; seen_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (run_chk) begin
                rgb = {vr, vg, vb};
                k = edges / 4;
                check("xclk", xclk, ((edges % 4) >= 2) ? 1 : 0);
                check("pwdn", pwdn, 0);
                check("cam_reset", cam_rst, 1);
                if (k == 0) begin
                    check("rst_hsync_n", hs_n, 1);
                    check("rst_vsync_n", vs_n, 1);
                    check("rst_rgb", rgb, 0);
                end else begin
                    p = k - 1;
                    x = p % H_TOT;
                    y = (p / H_TOT) % V_TOT;
                    exp_hs = !(x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC);
                    exp_vs = !(y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SYNC);
                    check("hsync_n", hs_n, exp_hs);
                    check("vsync_n", vs_n, exp_vs);
`ifdef TEST_CAM_UPSCALE_EN
                    in_img = (x < H_VIS) && (y < V_VIS) && ((x >> 2) < IMG_W) && ((y >> 2) < IMG_H);
                    a = (y >> 2) * IMG_W + (x >> 2);
`else
                    in_img = (x < IMG_W) && (y < IMG_H);
                    a = y * IMG_W + x;
`endif
                    if (!in_img) check("rgb_black", rgb, 0);
                    else if (chk_rgb) check("rgb_pixel", rgb, exp_mem[a]);

                    if (edges % 4 == 0) begin
                        if (!hs_n) hs_cnt++;
                        if (!seen_hs && !hs_n) begin
                            seen_hs = 1'b1;
                            check("first_hsync_enable", k, 657);
                        end
                        if (x == H_TOT - 1) begin
                            check("hsync_low_per_line", hs_cnt, 96);
                            hs_cnt = 0;
                            if (!vs_n) vs_cnt++;
                            if (y == V_TOT - 1) begin
                                check("vsync_lines_per_frame", vs_cnt, 2);
                                vs_cnt = 0;
                            end
                        end
                        if (p >= FRAME && p < 2 * FRAME) begin
`ifdef TEST_CAM_UPSCALE_EN
                            if (y == 0 && x < 8) check("up_blue", rgb, 12'h00F);
                            if (y == 0 && x >= 8 && x < 16) check("up_green", rgb, 12'h0F0);
`else
                            if (y == 0 && x < 4) check("line0_lit", rgb, lit_line0[x]);
                            if (y == 0 && x == IMG_W) check("x160_black", rgb, 0);
                            if (y == IMG_H && x == 0) check("yimg_black", rgb, 0);
`endif
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        @(posedge clk); #1;
        run_chk = 1'b1;
        repeat (19) @(posedge clk);
        #1 rst = 1'b0;

        idle(1'b1, 2 * 2 * IMG_W);
        idle(1'b0, 2 * 2 * IMG_W);
        pattern_line();
        idle(1'b0, 8);
        put_byte(1'b0, 1'b1, 8'hAB);
        idle(1'b0, 8);
        pattern_line();
        idle(1'b0, 8);
        pattern_line();
        idle(1'b0, 8);
        for (int i = 0; i < 2 * IMG_W; i++) put_byte(1'b0, 1'b1, 8'hA5 ^ 8'(i));
        idle(1'b0, 8);

        repeat (16) @(posedge clk);
        #1 chk_rgb = 1'b1;
        check("model_addr0", exp_mem[0], 12'h00F);
        check("model_addr1", exp_mem[1], 12'h00F);
        check("model_addr2", exp_mem[2], 12'h0F0);
        check("model_addr3", exp_mem[3], 12'h0F0);
        check("model_addr160", exp_mem[160], 12'h00F);
        check("model_addr_last", exp_mem[DEPTH - 1], 12'h0F0);

        while (edges < END_EDGES) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
